change_dispense_ctrl: RTL

CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

---
 rtl/change_dispense_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/change_dispense_ctrl.sv
// Change dispenser controller: greedy payout from three coin tubes (100/500/1000 won)
// with per-tube stock counters that also accept deposits.
module change_dispense_ctrl #(
   parameter int unsigned TUBE_W     = 8,
   parameter int unsigned INIT_STOCK = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_start,
   input  logic [13:0]       i_amount,
   input  logic [2:0]        i_coin_deposit,
   output logic [2:0]        o_return_coin,
   output logic              o_busy,
   output logic              o_done,
   output logic [13:0]       o_shortfall,
   output logic [TUBE_W-1:0] o_stock_100,
   output logic [TUBE_W-1:0] o_stock_500,
   output logic [TUBE_W-1:0] o_stock_1000
);

   localparam int unsigned AMT_W = 14;
   localparam int unsigned COIN_W = 3;

   localparam logic [AMT_W-1:0]  VAL_100    = AMT_W'(100);
   localparam logic [AMT_W-1:0]  VAL_500    = AMT_W'(500);
   localparam logic [AMT_W-1:0]  VAL_1000   = AMT_W'(1000);
   localparam logic [TUBE_W-1:0] STOCK_MAX  = '1;
   localparam logic [TUBE_W-1:0] STOCK_INIT = TUBE_W'(INIT_STOCK);

   typedef enum logic {
      IDLE     = 1'b0,
      DISPENSE = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [AMT_W-1:0]    rem_q, rem_d;
   logic [COIN_W-1:0]   coin_q, coin_d;
   logic                done_q, done_d;
   logic [AMT_W-1:0]    short_q, short_d;
   logic [TUBE_W-1:0]   stock_100_q, stock_100_d;
   logic [TUBE_W-1:0]   stock_500_q, stock_500_d;
   logic [TUBE_W-1:0]   stock_1000_q, stock_1000_d;
   logic [COIN_W-1:0]   disp;

   // Tube count update: saturating deposit, decrement on dispense; when both hit a
   // full tube the deposited coin cannot be stored, so the count still drops by one.
   function automatic logic [TUBE_W-1:0] tube_next(input logic [TUBE_W-1:0] cnt,
                                                   input logic dep,
                                                   input logic dsp);
      logic [TUBE_W-1:0] nxt;
      nxt = cnt;
      case ({dep, dsp})
         2'b10:   nxt = (cnt == STOCK_MAX) ? cnt : cnt + TUBE_W'(1);
         2'b01:   nxt = cnt - TUBE_W'(1);
         2'b11:   nxt = (cnt == STOCK_MAX) ? cnt - TUBE_W'(1) : cnt;
         default: nxt = cnt;
      endcase
      return nxt;
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rem_q        <= '0;
         coin_q       <= '0;
         done_q       <= 1'b0;
         short_q      <= '0;
         stock_100_q  <= STOCK_INIT;
         stock_500_q  <= STOCK_INIT;
         stock_1000_q <= STOCK_INIT;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         coin_q       <= coin_d;
         done_q       <= done_d;
         short_q      <= short_d;
         stock_100_q  <= stock_100_d;
         stock_500_q  <= stock_500_d;
         stock_1000_q <= stock_1000_d;
      end
   end

   // Next-state, greedy coin selection and tube bookkeeping.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      short_d = short_q;
      disp    = '0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = DISPENSE;
               rem_d   = i_amount;
            end
         end
         DISPENSE: begin
            if (rem_q >= VAL_1000 && stock_1000_q != '0) begin
               disp[2] = 1'b1;
               rem_d   = rem_q - VAL_1000;
            end else if (rem_q >= VAL_500 && stock_500_q != '0) begin
               disp[1] = 1'b1;
               rem_d   = rem_q - VAL_500;
            end else if (rem_q >= VAL_100 && stock_100_q != '0) begin
               disp[0] = 1'b1;
               rem_d   = rem_q - VAL_100;
            end else begin
               done_d  = 1'b1;
               short_d = rem_q;
               state_d = IDLE;
            end
         end
      endcase

      coin_d       = disp;
      stock_100_d  = tube_next(stock_100_q,  i_coin_deposit[0], disp[0]);
      stock_500_d  = tube_next(stock_500_q,  i_coin_deposit[1], disp[1]);
      stock_1000_d = tube_next(stock_1000_q, i_coin_deposit[2], disp[2]);
   end

   // Outputs come straight from registers.
   assign o_return_coin = coin_q;
   assign o_busy        = (state_q == DISPENSE);
   assign o_done        = done_q;
   assign o_shortfall   = short_q;
   assign o_stock_100   = stock_100_q;
   assign o_stock_500   = stock_500_q;
   assign o_stock_1000  = stock_1000_q;

endmodule
